impulse_capture_engine: RTL and testbench

Synthesizable, parametrised stimulus generator and response recorder for characterising the sample-rate datapath (SRRC transmit/receive filters) in-system. It arms on a start pulse, emits a programmable impulse, impulse train, alternating-sign train or step on the `sam_clk_en` grid, and records a fixed-length window of the device-under-test response into an internal buffer. The buffer is read back through a synchronous read port. The block replaces hand-written impulse benches and runs on `sys_clk` alongside `clk_gen`.

---
 rtl/impulse_capture_engine.sv | 175 +++++++++++++++++
 tb/tb_impulse_capture_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/impulse_capture_engine.sv
// rtl/impulse_capture_engine.sv - impulse/train/step stimulus generator with response capture buffer
// Drives stimulus on the sam_clk_en grid and records a DEPTH-sample response window.
module impulse_capture_engine #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 5
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     sam_clk_en,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic signed [DATA_W-1:0] amplitude,
  input  logic [ADDR_W-1:0]        offset,
  input  logic [ADDR_W-1:0]        period,
  output logic signed [DATA_W-1:0] stimulus,
  input  logic signed [DATA_W-1:0] response,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          capture_count,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_TRAIN  = 2'd1;
  localparam logic [1:0] MODE_STEP   = 2'd2;

  typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, DONE} state_t;

  state_t state, state_next;

  logic [1:0]               mode_r;
  logic signed [DATA_W-1:0] amp_r;
  logic [ADDR_W-1:0]        offset_r;
  logic [ADDR_W-1:0]        period_r;
  logic [ADDR_W-1:0]        k;
  logic [ADDR_W-1:0]        phase;
  logic                     negate_next;

  logic signed [DATA_W-1:0] mem [DEPTH];

  logic                     accept, fire, cap_we, cancel, finish;
  logic [ADDR_W-1:0]        period_eff, phase_inc;
  logic                     hit;
  logic signed [DATA_W-1:0] amp_neg, stim_next;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fire       = 1'b0;
    cap_we     = 1'b0;
    cancel     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = DELAY;
        end
      end
      DELAY: begin
        if (abort) begin
          cancel     = 1'b1;
          state_next = IDLE;
        end else if (sam_clk_en && (k == offset_r)) begin
          fire       = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          cancel     = 1'b1;
          state_next = IDLE;
        end else if (sam_clk_en) begin
          cap_we = 1'b1;
          if (capture_count == LAST_IDX) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // phase counts strobes since the last impulse; hit marks the next train impulse
  always_comb begin
    period_eff = (period_r == '0) ? ADDR_W'(1) : period_r;
    phase_inc  = phase + 1'b1;
    hit        = (phase_inc == period_eff);
    amp_neg    = (amp_r == MOST_NEG) ? MOST_POS : -amp_r;
    case (mode_r)
      MODE_SINGLE: stim_next = '0;
      MODE_TRAIN:  stim_next = hit ? amp_r : '0;
      MODE_STEP:   stim_next = amp_r;
      default:     stim_next = hit ? (negate_next ? amp_neg : amp_r) : '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      stimulus      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      capture_count <= '0;
      rd_data       <= '0;
      mode_r        <= '0;
      amp_r         <= '0;
      offset_r      <= '0;
      period_r      <= '0;
      k             <= '0;
      phase         <= '0;
      negate_next   <= 1'b0;
    end else begin
      done    <= finish;
      rd_data <= mem[rd_addr];
      if (accept) begin
        mode_r        <= mode;
        amp_r         <= amplitude;
        offset_r      <= offset;
        period_r      <= period;
        k             <= '0;
        capture_count <= '0;
        busy          <= 1'b1;
      end
      if ((state == DELAY) && sam_clk_en && !abort && !fire) begin
        k <= k + 1'b1;
      end
      if (fire) begin
        stimulus    <= amp_r;
        phase       <= '0;
        negate_next <= 1'b1;
      end
      if (cap_we) begin
        capture_count <= capture_count + 1'b1;
        stimulus      <= stim_next;
        if (hit) begin
          phase       <= '0;
          negate_next <= ~negate_next;
        end else begin
          phase <= phase_inc;
        end
      end
      if (cancel || finish) begin
        stimulus <= '0;
        busy     <= 1'b0;
      end
    end
  end

  // buffer contents survive reset; only the write is suppressed while reset is high
  always_ff @(posedge sys_clk) begin
    if (cap_we && !reset) begin
      mem[capture_count[ADDR_W-1:0]] <= response;
    end
  end

endmodule

// File: tb/tb_impulse_capture_engine.sv
// tb/tb_impulse_capture_engine.sv - randomized self-checking bench for impulse_capture_engine
module tb_impulse_capture_engine;

  localparam int DATA_W = 18;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic                     sys_clk = 1'b0;
  logic                     reset;
  logic                     sam_clk_en;
  logic                     start;
  logic                     abort;
  logic [1:0]               mode;
  logic signed [DATA_W-1:0] amplitude;
  logic [ADDR_W-1:0]        offset;
  logic [ADDR_W-1:0]        period;
  logic signed [DATA_W-1:0] stimulus;
  logic signed [DATA_W-1:0] response = '0;
  logic                     busy;
  logic                     done;
  logic [ADDR_W:0]          capture_count;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_mem [DEPTH];

  impulse_capture_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .sam_clk_en(sam_clk_en),
    .start(start),
    .abort(abort),
    .mode(mode),
    .amplitude(amplitude),
    .offset(offset),
    .period(period),
    .stimulus(stimulus),
    .response(response),
    .busy(busy),
    .done(done),
    .capture_count(capture_count),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 sys_clk = ~sys_clk;

  // device under characterisation: a one-cycle registered wire
  always @(posedge sys_clk) response <= stimulus;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  function automatic int sat_neg(int a);
    return (a == -(1 << (DATA_W-1))) ? (1 << (DATA_W-1)) - 1 : -a;
  endfunction

  // expected stimulus after the strobe with index k
  function automatic int model_stim(int md, int amp, int off, int per, int k);
    int p;
    int n;
    p = (per == 0) ? 1 : per;
    if (k < off) return 0;
    n = k - off;
    case (md)
      0: return (n == 0) ? amp : 0;
      1: return (n % p == 0) ? amp : 0;
      2: return amp;
      default: begin
        if (n % p != 0) return 0;
        return ((n / p) % 2 == 1) ? sat_neg(amp) : amp;
      end
    endcase
  endfunction

  // stop_at: captures after which the run is cancelled (-1 runs to completion)
  task automatic run(input int md, input int amp, input int off, input int per,
                     input int stop_at, input bit by_reset);
    int total;
    int exp_s;
    int caps;
    int gap;
    total = off + 1 + DEPTH;
    exp_s = 0;
    caps  = 0;
    mode      = 2'(md);
    amplitude = DATA_W'(amp);
    offset    = ADDR_W'(off);
    period    = ADDR_W'(per);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("count_clr", capture_count, 0);
    mode      = 2'($urandom);
    amplitude = DATA_W'($urandom);
    offset    = ADDR_W'($urandom);
    period    = ADDR_W'($urandom);
    for (int s = 0; s < total; s++) begin
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        start = ($urandom_range(0, 3) == 0);
        tick;
        start = 1'b0;
        check("hold_stim", stimulus, exp_s);
        check("hold_busy", busy, 1);
      end
      sam_clk_en = 1'b1;
      tick;
      sam_clk_en = 1'b0;
      if (s > off) begin
        exp_mem[caps] = exp_s;
        caps++;
      end
      exp_s = model_stim(md, amp, off, per, s);
      check("stim", stimulus, exp_s);
      check("count", capture_count, caps);
      check("done_low", done, 0);
      if (caps == stop_at) begin
        if (by_reset) begin
          reset = 1'b1;
          start = 1'b1;
          tick;
          reset = 1'b0;
          start = 1'b0;
          check("rst_busy", busy, 0);
          check("rst_stim", stimulus, 0);
          check("rst_count", capture_count, 0);
          check("rst_done", done, 0);
          check("rst_rd", rd_data, 0);
          for (int i = 0; i < 3; i++) begin
            sam_clk_en = 1'b1;
            tick;
            sam_clk_en = 1'b0;
            tick;
            check("rst_idle_busy", busy, 0);
            check("rst_idle_count", capture_count, 0);
          end
        end else begin
          abort      = 1'b1;
          sam_clk_en = 1'b1;
          tick;
          abort      = 1'b0;
          sam_clk_en = 1'b0;
          check("ab_busy", busy, 0);
          check("ab_stim", stimulus, 0);
          check("ab_count", capture_count, stop_at);
          for (int i = 0; i < 3; i++) begin
            sam_clk_en = 1'b1;
            tick;
            sam_clk_en = 1'b0;
            check("ab_done", done, 0);
            check("ab_hold_count", capture_count, stop_at);
          end
        end
        return;
      end
    end
    check("last_busy", busy, 1);
    tick;
    check("done_pulse", done, 1);
    check("end_busy", busy, 0);
    check("end_stim", stimulus, 0);
    check("end_count", capture_count, DEPTH);
    tick;
    check("done_fall", done, 0);
  endtask

  task automatic sweep;
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = ADDR_W'(a);
      tick;
      check("rd_data", rd_data, exp_mem[a]);
    end
  endtask

  initial begin
    int md;
    int amp;
    int off;
    int per;
    reset      = 1'b1;
    sam_clk_en = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    mode       = '0;
    amplitude  = '0;
    offset     = '0;
    period     = '0;
    rd_addr    = '0;
    repeat (3) tick;
    check("reset_stim", stimulus, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_count", capture_count, 0);
    check("reset_rd", rd_data, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    check("reset_beats_start", busy, 0);
    reset = 1'b0;
    tick;

    run(0, 65536, 3, 0, -1, 1'b0);
    sweep;
    run(3, 100, 0, 4, -1, 1'b0);
    sweep;
    run(3, -131072, 0, 4, -1, 1'b0);
    sweep;
    run(2, -5, 2, 1, -1, 1'b0);
    run(1, 777, 1, 0, -1, 1'b0);
    sweep;
    run(0, 1234, 0, 3, 10, 1'b0);
    sweep;
    run(2, 999, 4, 2, -1, 1'b0);
    sweep;
    run(1, 50, 1, 3, 5, 1'b1);
    for (int r = 0; r < 6; r++) begin
      md  = $urandom_range(0, 3);
      amp = ($urandom_range(0, 4) == 0) ? -131072 : $urandom_range(0, 262143) - 131072;
      off = $urandom_range(0, 12);
      per = $urandom_range(0, 6);
      run(md, amp, off, per, -1, 1'b0);
      sweep;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
